// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared ALU with watchdog
module alu_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [4:0]  req0_op,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_fault,
  output logic        rsp_timeout,
  output logic        alu_available,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_busy,
  input  logic        alu_fault
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0] state;
  logic       grant;
  logic       last_grant;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       winner;
  logic       wait_done;
  logic       wait_expired;

  // Arbitration and state-decoded outputs; reset masks every strobe in its own cycle
  always_comb begin
    winner       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept       = !reset && (state == S_IDLE) && (req0_valid || req1_valid);
    req_ready    = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
    alu_available = !reset && ((state == S_ISSUE) || (state == S_WAIT));
    rsp_valid    = (!reset && (state == S_RELEASE)) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    // The first WAIT cycle (count 0) never completes, so the ALU always sees a full handshake
    wait_done    = !alu_busy && (wait_cnt != 8'd0);
    wait_expired = (wait_cnt == TIMEOUT_CNT);
  end

  // Control FSM, operand latch, watchdog counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      wait_cnt    <= 8'd0;
      alu_op      <= 5'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      rsp_result  <= 32'd0;
      rsp_fault   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_op     <= winner ? req1_op : req0_op;
            alu_a      <= winner ? req1_a  : req0_a;
            alu_b      <= winner ? req1_b  : req0_b;
            grant      <= winner;
            last_grant <= winner;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= 8'd0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_done) begin
            rsp_result  <= alu_out;
            rsp_fault   <= alu_fault;
            rsp_timeout <= 1'b0;
            state       <= S_RELEASE;
          end else if (wait_expired) begin
            rsp_result  <= 32'd0;
            rsp_fault   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= S_RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum cycles spent in WAIT before abort (range 2..255).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_op / req1_op  input  5  ALU op code, same encoding as the ALU op port.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 req_ready  output  2  bit i = request i accepted this cycle; one-hot or zero.
REQ-008 rsp_valid  output  2  bit i = response for requester i valid this cycle; one-cycle pulse, one-hot or zero.
REQ-009 rsp_result  output  32  ALU result, valid with rsp_valid.
REQ-010 rsp_fault  output  1  ALU fault or timeout, valid with rsp_valid.
REQ-011 rsp_timeout  output  1  operation aborted by watchdog, valid with rsp_valid.
REQ-012 alu_available  output  1  drives ALU available.
REQ-013 alu_op  output  5; alu_a, alu_b  output  32  latched operation to ALU.
REQ-014 alu_out  input  32; alu_busy  input  1; alu_fault  input  1  from ALU.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT, RELEASE; encoding is free, with no reachable unlisted state.
REQ-016 IDLE: if any req_valid, the winner's req_ready bit SHALL be driven combinationally, its op/a/b latched into alu_op/alu_a/alu_b, grant index latched, next state ISSUE; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; the pointer updates only on acceptance.
REQ-018 After reset, the first tie SHALL go to requester 0.
REQ-019 ISSUE: alu_available=1 for exactly one cycle, WAIT counter cleared, next WAIT.
REQ-020 WAIT: alu_available=1, counter increments.
REQ-021 WAIT exit to RELEASE SHALL occur when alu_busy=0 and the counter is at least 1, i.e. no earlier than the second WAIT cycle.
REQ-022 On the WAIT exit, rsp_result<=alu_out, rsp_fault<=alu_fault, and rsp_timeout<=0 SHALL be registered.
REQ-023 Watchdog: if the counter reaches TIMEOUT while still in WAIT, go to RELEASE with rsp_result=0, rsp_fault=1, rsp_timeout=1.
REQ-024 RELEASE: alu_available=0, rsp_valid[grant]=1 for one cycle, next IDLE.
REQ-025 With a conforming ALU, latency SHALL be: accept at cycle T, alu_available high T+1..T+3, rsp_valid at T+4.
REQ-026 Peak throughput SHALL be one operation per 5 cycles; next acceptance no earlier than T+5.
REQ-027 req_ready SHALL be 0 in all states other than IDLE; pending requests wait and inputs are not sampled.
REQ-028 Requester input changes after acceptance SHALL NOT affect alu_op/alu_a/alu_b or the response.
REQ-029 req_valid still high at T+5 SHALL be treated as a new request.
REQ-030 alu_op/alu_a/alu_b SHALL hold stable from ISSUE through RELEASE.
REQ-031 rsp_result/rsp_fault/rsp_timeout SHALL hold until the next RELEASE.
REQ-032 Invalid ALU ops SHALL be forwarded unchanged; fault is reported through rsp_fault only, and arbitration is unaffected.

Reset
REQ-033 On reset the block SHALL enter IDLE, including mid-operation.
REQ-034 Reset values: alu_available=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_fault=0, rsp_timeout=0, alu_op/alu_a/alu_b=0, round-robin pointer=1, WAIT counter=0.
REQ-035 An operation interrupted by reset SHALL produce no rsp_valid; reset overrides all other events in the same cycle.

Verification
REQ-036 req0 valid only, op=00000, a=5, b=7 at T -> req_ready=01 at T; rsp_valid=01 at T+4, rsp_result=12, rsp_fault=0.
REQ-037 req0 and req1 both valid continuously, req1 op=01000, a=3, b=5 -> grants alternate 0,1,0 at T, T+5, T+10; req1 rsp_result=0xFFFFFFFE.
REQ-038 req1 op=11111 -> rsp_valid=10, rsp_fault=1, rsp_timeout=0.
REQ-039 ALU model holds alu_busy=1 forever -> rsp_valid at WAIT cycle TIMEOUT+1, rsp_fault=1, rsp_timeout=1, rsp_result=0; next request then accepted normally.
REQ-040 reset asserted at T+2 of an operation -> alu_available=0 at T+3, no rsp_valid; subsequent request with both valid granted to requester 0.
REQ-041 req0 a/b changed at T+1 after acceptance -> result reflects values sampled at T.
